gpr_writeback_arbiter: RTL and testbench
========================================

// Module: gpr_writeback_arbiter
// PURPOSE
//  Writeback stage directly upstream of the 32-entry GPR file (2 read ports, 1 write port).
//  Merges two result producers into the single GPR write port:
//  - execute pipe (EX): unbuffered, high priority.
//  - load-return path (LD): buffered in a small FIFO, with starvation protection.
//  Drives the GPR write enable, address and data from registers, and pulses a scoreboard-clear.
// PARAMETERS
//  DATA_W     64  result/GPR data width; tie to `GPU_DDATA_WIDTH
//  LD_DEPTH   2   load-return FIFO entries; power of 2, >=2
//  STARVE_MAX 3   consecutive lost arbitrations by a non-empty LD FIFO before LD is forced to win
// PORTS
//  clk          in   1       clock; all state on posedge
//  rst_n        in   1       asynchronous active-low reset
//  ex_valid     in   1       EX result valid
//  ex_ready     out  1       EX result accepted this cycle when ex_valid&ex_ready
//  ex_rd        in   5       EX destination register
//  ex_data      in   DATA_W  EX result
//  ld_valid     in   1       load return valid
//  ld_ready     out  1       = !fifo_full (registered state, not combinational on ld_valid)
//  ld_rd        in   5       load destination register
//  ld_data      in   DATA_W  load data
//  wb_en        out  1       GPR write enable (to GPR clk_en)
//  wb_addr      out  5       GPR write address (to rd0_addr)
//  wb_data      out  DATA_W  GPR write data (to rd0_data)
//  sb_clr       out  1       scoreboard clear pulse for sb_clr_rd; includes rd==0
//  sb_clr_rd    out  5       register whose pending bit is cleared
//  ld_count     out  $clog2(LD_DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset: wb_en=0, wb_addr=0, wb_data=0, sb_clr=0, sb_clr_rd=0; FIFO empty; ld_count=0; starve_cnt=0; FSM=EX_PRI.
//  Mid-operation reset drops all FIFO contents and any staged write. No write is issued on the edge after release.
//  FSM states:
//  - EX_PRI: EX wins when ex_valid. Otherwise the FIFO head wins if non-empty.
//  - LD_FORCE: the FIFO head wins unconditionally; ex_ready=0.
//  FSM transitions:
//  - EX_PRI->LD_FORCE when the FIFO is non-empty, EX wins, and starve_cnt==STARVE_MAX-1.
//  - LD_FORCE->EX_PRI after exactly one cycle.
//  starve_cnt:
//  - +1 when the FIFO is non-empty and EX wins.
//  - Cleared when LD wins or the FIFO is empty.
//  - Saturates at STARVE_MAX-1.
//  ex_ready = (state==EX_PRI). It is independent of ex_valid.
//  Grant G (EX or LD) in cycle N: on edge N+1, wb_addr<=G.rd, wb_data<=G.data, wb_en<=(G.rd!=0), sb_clr<=1, sb_clr_rd<=G.rd.
//  No grant: wb_en<=0 and sb_clr<=0. wb_addr and wb_data hold their previous values.
//  Writeback latency is 1 cycle; the result is readable from the GPR on the cycle after wb_en.
//  rd==0: the result is consumed and scoreboard-cleared, but wb_en stays 0.
//  FIFO push on ld_valid&ld_ready. Pop on LD grant.
//  - Push and pop in the same cycle: occupancy unchanged; allowed whenever not full.
//  - When full, ld_ready=0 even if a pop occurs in that cycle (no full-pass-through).
//  - Pointers wrap modulo LD_DEPTH.
//  - An empty FIFO never wins; there is no bypass from ld_* into arbitration.
//  - A load arriving this cycle is earliest granted next cycle.
//  Ordering: no same-rd ordering between EX and LD is enforced; the scoreboard guarantees at most one in-flight writer per rd.
// CONFIGURATION
//  Macro GPR_WB_BYPASS_EN.
//  Defined: adds outputs byp_valid(1), byp_rd(5), byp_data(DATA_W).
//  - Combinationally present the grant of cycle N with byp_valid=grant&&rd!=0.
//  - This feeds operand bypass one cycle ahead of the GPR write.
//  Undefined: the ports are absent. The design is otherwise cycle-identical.
// STRUCTURE
//  global_defines.vh holds GPU_DDATA_WIDTH, GPR_ADDR_W=5, and WB FSM encodings (EX_PRI=1'b0, LD_FORCE=1'b1).
//  Sub-module gpr_wb_ld_fifo: parameterised LD_DEPTH x (5+DATA_W) FIFO.
//  - Ports: push, pop, din, dout, full, empty, count; async active-low reset.
//  The top level holds the arbiter FSM, starvation counter and output registers.
// TESTING
//  1. Reset: assert rst_n=0 mid-stream with FIFO count=2 -> all outputs 0 and ld_count=0 immediately; ld_ready=1 after release.
//  2. EX only: ex_valid=1, rd=5, data=64'hA5 -> ex_ready=1; next cycle wb_en=1, wb_addr=5, wb_data=64'hA5, sb_clr=1.
//  3. Starvation: ex_valid held 1, one load rd=7 queued, STARVE_MAX=3 -> EX wins 3 cycles, then ex_ready=0 for 1 cycle; wb_addr=7 one cycle later.
//  4. FIFO full: ld_valid held 1 while EX saturates -> ld_ready=0 once ld_count=2; no overwrite; both loads written back in order.
//  5. rd0: EX rd=0, data=64'hFF -> wb_en=0, sb_clr=1, sb_clr_rd=0; GPR x0 reads 0.
//  6. With GPR_WB_BYPASS_EN: grant rd=9 data=64'h1234 -> byp_valid=1, byp_rd=9 in the same cycle; wb_en=1 on the following cycle.

Source files
------------

// File: rtl/gpr_writeback_arbiter_pkg.sv
// rtl/gpr_writeback_arbiter_pkg.sv - shared widths and writeback FSM encoding
package gpr_writeback_arbiter_pkg;

  // Default result / GPR data width.
  localparam int GPU_DDATA_WIDTH = 64;

  // 32-entry GPR file address width.
  localparam int GPR_ADDR_W = 5;

  // Writeback arbiter states: EX normally has priority; LD_FORCE lasts one cycle.
  typedef enum logic {
    EX_PRI   = 1'b0,
    LD_FORCE = 1'b1
  } wb_state_e;

endpackage

// File: rtl/gpr_wb_ld_fifo.sv
// rtl/gpr_wb_ld_fifo.sv - load-return FIFO holding {rd, data} entries
module gpr_wb_ld_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Storage is written on push only; stale entries are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gpr_writeback_arbiter.sv
// rtl/gpr_writeback_arbiter.sv - EX/LD merge into the single GPR write port; optional GPR_WB_BYPASS_EN
module gpr_writeback_arbiter
  import gpr_writeback_arbiter_pkg::*;
#(
  parameter int DATA_W     = GPU_DDATA_WIDTH,
  parameter int LD_DEPTH   = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ex_valid,
  output logic                       ex_ready,
  input  logic [4:0]                 ex_rd,
  input  logic [DATA_W-1:0]          ex_data,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [4:0]                 ld_rd,
  input  logic [DATA_W-1:0]          ld_data,
  output logic                       wb_en,
  output logic [4:0]                 wb_addr,
  output logic [DATA_W-1:0]          wb_data,
  output logic                       sb_clr,
  output logic [4:0]                 sb_clr_rd,
  output logic [$clog2(LD_DEPTH):0]  ld_count
`ifdef GPR_WB_BYPASS_EN
  ,
  output logic                       byp_valid,
  output logic [4:0]                 byp_rd,
  output logic [DATA_W-1:0]          byp_data
`endif
);

  localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam int EW = GPR_ADDR_W + DATA_W;

  wb_state_e         state;
  wb_state_e         state_nxt;
  logic [SW-1:0]     starve_cnt;
  logic [SW-1:0]     starve_nxt;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic [EW-1:0]     fifo_dout;
  logic              ex_grant;
  logic              ld_grant;
  logic              grant;
  logic [4:0]        g_rd;
  logic [DATA_W-1:0] g_data;

  assign fifo_push = ld_valid & ~fifo_full;
  assign ld_ready  = ~fifo_full;
  assign ex_ready  = (state == EX_PRI);

  gpr_wb_ld_fifo #(
    .WIDTH (EW),
    .DEPTH (LD_DEPTH)
  ) u_ld_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (ld_grant),
    .din   ({ld_rd, ld_data}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (ld_count)
  );

  // Arbitration, starvation tracking and next state.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    ex_grant   = 1'b0;
    ld_grant   = 1'b0;
    case (state)
      EX_PRI: begin
        if (ex_valid)         ex_grant = 1'b1;
        else if (!fifo_empty) ld_grant = 1'b1;
      end
      LD_FORCE: begin
        ld_grant  = ~fifo_empty;
        state_nxt = EX_PRI;
      end
      default: state_nxt = EX_PRI;
    endcase
    if (fifo_empty || ld_grant) begin
      starve_nxt = '0;
    end else if (ex_grant) begin
      if (starve_cnt == SW'(STARVE_MAX - 1)) state_nxt  = LD_FORCE;
      else                                   starve_nxt = starve_cnt + SW'(1);
    end
  end

  assign grant  = ex_grant | ld_grant;
  assign g_rd   = ex_grant ? ex_rd   : fifo_dout[EW-1:DATA_W];
  assign g_data = ex_grant ? ex_data : fifo_dout[DATA_W-1:0];

`ifdef GPR_WB_BYPASS_EN
  assign byp_valid = grant && (g_rd != 5'd0);
  assign byp_rd    = g_rd;
  assign byp_data  = g_data;
`endif

  // FSM state and starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EX_PRI;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Registered GPR write port and scoreboard clear; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      sb_clr    <= 1'b0;
      sb_clr_rd <= '0;
    end else if (grant) begin
      wb_en     <= (g_rd != 5'd0);
      wb_addr   <= g_rd;
      wb_data   <= g_data;
      sb_clr    <= 1'b1;
      sb_clr_rd <= g_rd;
    end else begin
      wb_en  <= 1'b0;
      sb_clr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gpr_writeback_arbiter.sv
// tb/tb_gpr_writeback_arbiter.sv - randomized and directed bench for gpr_writeback_arbiter
module tb_gpr_writeback_arbiter;

  localparam int DATA_W     = 64;
  localparam int LD_DEPTH   = 2;
  localparam int STARVE_MAX = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ex_valid = 1'b0;
  logic              ex_ready;
  logic [4:0]        ex_rd = '0;
  logic [DATA_W-1:0] ex_data = '0;
  logic              ld_valid = 1'b0;
  logic              ld_ready;
  logic [4:0]        ld_rd = '0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              wb_en;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              sb_clr;
  logic [4:0]        sb_clr_rd;
  logic [1:0]        ld_count;
`ifdef GPR_WB_BYPASS_EN
  logic              byp_valid;
  logic [4:0]        byp_rd;
  logic [DATA_W-1:0] byp_data;
  logic              obs_byp_valid;
  logic [4:0]        obs_byp_rd;
  logic [DATA_W-1:0] obs_byp_data;
`endif

  gpr_writeback_arbiter #(
    .DATA_W     (DATA_W),
    .LD_DEPTH   (LD_DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_rd     (ex_rd),
    .ex_data   (ex_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .sb_clr    (sb_clr),
    .sb_clr_rd (sb_clr_rd),
    .ld_count  (ld_count)
`ifdef GPR_WB_BYPASS_EN
    ,
    .byp_valid (byp_valid),
    .byp_rd    (byp_rd),
    .byp_data  (byp_data)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queue of pending loads, count of arbitrations lost by waiting loads.
  logic [68:0]       m_q[$];
  int                m_losses;
  bit                m_force;

  // Expected / observed values of the most recent cycle.
  logic              exp_ex_ready, exp_ld_ready;
  int                exp_ld_count;
  logic              obs_ex_ready, obs_ld_ready;
  logic [1:0]        obs_ld_count;
  logic              exp_wb_en, exp_sb_clr;
  logic [4:0]        exp_wb_addr, exp_sb_clr_rd;
  logic [DATA_W-1:0] exp_wb_data;
  bit                last_ld_accept;

  task automatic model_reset();
    m_q.delete();
    m_losses      = 0;
    m_force       = 0;
    exp_wb_en     = 1'b0;
    exp_sb_clr    = 1'b0;
    exp_wb_addr   = '0;
    exp_sb_clr_rd = '0;
    exp_wb_data   = '0;
  endtask

  // Apply one cycle of inputs, capture pre-edge outputs, advance the model; returns at posedge+1.
  task automatic drive_cycle(input logic ev, input logic [4:0] erd, input logic [DATA_W-1:0] ed,
                             input logic lv, input logic [4:0] lrd, input logic [DATA_W-1:0] ldd);
    bit                gex, gld;
    logic [4:0]        grd;
    logic [DATA_W-1:0] gd;
    logic [68:0]       head;
    ex_valid = ev; ex_rd = erd; ex_data = ed;
    ld_valid = lv; ld_rd = lrd; ld_data = ldd;
    @(negedge clk);
    obs_ex_ready = ex_ready;
    obs_ld_ready = ld_ready;
    obs_ld_count = ld_count;
`ifdef GPR_WB_BYPASS_EN
    obs_byp_valid = byp_valid;
    obs_byp_rd    = byp_rd;
    obs_byp_data  = byp_data;
`endif
    exp_ex_ready = !m_force;
    exp_ld_ready = (m_q.size() < LD_DEPTH);
    exp_ld_count = m_q.size();
    gex = 0; gld = 0; grd = '0; gd = '0;
    if (m_force)             gld = (m_q.size() != 0);
    else if (ev)             gex = 1;
    else if (m_q.size() != 0) gld = 1;
    if (m_q.size() == 0 || gld) m_losses = 0;
    else if (gex)               m_losses = m_losses + 1;
    m_force = (m_losses >= STARVE_MAX);
    if (gld) begin
      head = m_q.pop_front();
      grd  = head[68:64];
      gd   = head[63:0];
    end else if (gex) begin
      grd = erd;
      gd  = ed;
    end
    last_ld_accept = lv && exp_ld_ready;
    if (last_ld_accept) m_q.push_back({lrd, ldd});
    @(posedge clk);
    #1;
    if (gex || gld) begin
      exp_wb_en     = (grd != 5'd0);
      exp_wb_addr   = grd;
      exp_wb_data   = gd;
      exp_sb_clr    = 1'b1;
      exp_sb_clr_rd = grd;
    end else begin
      exp_wb_en  = 1'b0;
      exp_sb_clr = 1'b0;
    end
  endtask

  // Idle until the model holds no pending loads and no forced cycle.
  task automatic drain();
    int k;
    k = 0;
    while ((m_q.size() != 0 || m_force) && k < 20) begin
      drive_cycle(0, '0, '0, 0, '0, '0);
      k++;
    end
    drive_cycle(0, '0, '0, 0, '0, '0);
    n_vec++;
    if (m_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: model queue %0d after %0d cycles, required 0", m_q.size(), k);
    end
  endtask

  task automatic test_reset();
    #1;
    n_vec++; if (wb_en !== 1'b0)   begin n_err++; $display("FAIL reset_wb_en: got %b want 0", wb_en); end
    n_vec++; if (wb_addr !== 5'd0) begin n_err++; $display("FAIL reset_wb_addr: got %0d want 0", wb_addr); end
    n_vec++; if (wb_data !== '0)   begin n_err++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
    n_vec++; if (sb_clr !== 1'b0)  begin n_err++; $display("FAIL reset_sb_clr: got %b want 0", sb_clr); end
    n_vec++; if (ld_count !== 2'd0) begin n_err++; $display("FAIL reset_ld_count: got %0d want 0", ld_count); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    n_vec++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL reset_ld_ready: got %b want 1", ld_ready); end
    drive_cycle(0, '0, '0, 0, '0, '0);
    n_vec++; if (wb_en !== 1'b0 || sb_clr !== 1'b0) begin
      n_err++; $display("FAIL reset_first_edge: wb_en=%b sb_clr=%b want 0 0", wb_en, sb_clr);
    end
  endtask

  task automatic test_ex_only();
    drain();
    drive_cycle(1, 5'd5, 64'hA5, 0, '0, '0);
    n_vec++; if (obs_ex_ready !== 1'b1) begin n_err++; $display("FAIL ex_only_ready: got %b want 1", obs_ex_ready); end
    n_vec++; if (wb_en !== 1'b1)        begin n_err++; $display("FAIL ex_only_wb_en: got %b want 1", wb_en); end
    n_vec++; if (wb_addr !== 5'd5)      begin n_err++; $display("FAIL ex_only_wb_addr: got %0d want 5", wb_addr); end
    n_vec++; if (wb_data !== 64'hA5)    begin n_err++; $display("FAIL ex_only_wb_data: got %h want a5", wb_data); end
    n_vec++; if (sb_clr !== 1'b1 || sb_clr_rd !== 5'd5) begin
      n_err++; $display("FAIL ex_only_sb_clr: got %b/%0d want 1/5", sb_clr, sb_clr_rd);
    end
    drive_cycle(0, '0, '0, 0, '0, '0);
    n_vec++; if (wb_en !== 1'b0 || wb_addr !== 5'd5 || wb_data !== 64'hA5) begin
      n_err++; $display("FAIL ex_only_hold: wb_en=%b addr=%0d data=%h want 0 5 a5", wb_en, wb_addr, wb_data);
    end
  endtask

  task automatic test_starvation();
    logic want_ready;
    drain();
    for (int c = 0; c < 5; c++) begin
      drive_cycle(1, 5'd1, 64'h100 + c, (c == 0), 5'd7, 64'h77);
      want_ready = (c != 4);
      n_vec++; if (obs_ex_ready !== want_ready) begin
        n_err++; $display("FAIL starve_ex_ready_c%0d: got %b want %b", c, obs_ex_ready, want_ready);
      end
    end
    n_vec++; if (wb_en !== 1'b1 || wb_addr !== 5'd7 || wb_data !== 64'h77) begin
      n_err++; $display("FAIL starve_ld_wb: en=%b addr=%0d data=%h want 1 7 77", wb_en, wb_addr, wb_data);
    end
    drive_cycle(1, 5'd1, 64'h200, 0, '0, '0);
    n_vec++; if (obs_ex_ready !== 1'b1 || wb_addr !== 5'd1) begin
      n_err++; $display("FAIL starve_recover: ready=%b addr=%0d want 1 1", obs_ex_ready, wb_addr);
    end
  endtask

  task automatic test_fifo_full();
    int          nl;
    bit          saw_full;
    logic [68:0] got[$];
    drain();
    nl = 0; saw_full = 0;
    for (int c = 0; c < 24; c++) begin
      drive_cycle(1, 5'd3, 64'h300 + c, 1, 5'd10 + 5'(nl), 64'hD00 + nl);
      if (last_ld_accept) nl++;
      n_vec++; if (obs_ld_count !== 2'(exp_ld_count)) begin
        n_err++; $display("FAIL full_count_c%0d: got %0d want %0d", c, obs_ld_count, exp_ld_count);
      end
      if (exp_ld_count == LD_DEPTH) begin
        saw_full = 1;
        n_vec++; if (obs_ld_ready !== 1'b0) begin
          n_err++; $display("FAIL full_ld_ready_c%0d: got %b want 0", c, obs_ld_ready);
        end
      end
      if (sb_clr === 1'b1 && sb_clr_rd >= 5'd10) got.push_back({sb_clr_rd, wb_data});
    end
    n_vec++; if (!saw_full) begin n_err++; $display("FAIL full_reached: got 0 want 1"); end
    n_vec++; if (got.size() < 2) begin
      n_err++; $display("FAIL full_loads_out: got %0d want >=2", got.size());
    end else begin
      n_vec++; if (got[0] !== {5'd10, 64'hD00} || got[1] !== {5'd11, 64'hD01}) begin
        n_err++; $display("FAIL full_order: got %h %h want 0a/d00 0b/d01", got[0], got[1]);
      end
    end
  endtask

  task automatic test_rd0();
    drain();
    drive_cycle(1, 5'd0, 64'hFF, 0, '0, '0);
    n_vec++; if (wb_en !== 1'b0)  begin n_err++; $display("FAIL rd0_wb_en: got %b want 0", wb_en); end
    n_vec++; if (sb_clr !== 1'b1 || sb_clr_rd !== 5'd0) begin
      n_err++; $display("FAIL rd0_sb_clr: got %b/%0d want 1/0", sb_clr, sb_clr_rd);
    end
  endtask

  task automatic test_mid_reset();
    drain();
    drive_cycle(1, 5'd4, 64'h44, 1, 5'd12, 64'hC1);
    drive_cycle(1, 5'd4, 64'h45, 1, 5'd13, 64'hC2);
    drive_cycle(1, 5'd4, 64'h46, 0, '0, '0);
    n_vec++; if (obs_ld_count !== 2'd2) begin n_err++; $display("FAIL midrst_pre_count: got %0d want 2", obs_ld_count); end
    ex_valid = 1'b0; ld_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (wb_en !== 1'b0 || sb_clr !== 1'b0 || wb_addr !== 5'd0 || wb_data !== '0 || sb_clr_rd !== 5'd0) begin
      n_err++; $display("FAIL midrst_outputs: en=%b clr=%b addr=%0d data=%h rd=%0d want all 0", wb_en, sb_clr, wb_addr, wb_data, sb_clr_rd);
    end
    n_vec++; if (ld_count !== 2'd0) begin n_err++; $display("FAIL midrst_count: got %0d want 0", ld_count); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    n_vec++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ld_ready: got %b want 1", ld_ready); end
    drive_cycle(0, '0, '0, 0, '0, '0);
    n_vec++; if (wb_en !== 1'b0 || sb_clr !== 1'b0) begin
      n_err++; $display("FAIL midrst_no_stale: en=%b clr=%b want 0 0", wb_en, sb_clr);
    end
  endtask

  task automatic test_random();
    logic              ev, lv;
    logic [4:0]        erd, lrd;
    logic [DATA_W-1:0] ed, ldd;
    for (int c = 0; c < 400; c++) begin
      ev  = ($urandom_range(0, 99) < 60);
      lv  = ($urandom_range(0, 99) < 45);
      erd = 5'($urandom_range(0, 31));
      lrd = 5'($urandom_range(0, 31));
      ed  = {$urandom, $urandom};
      ldd = {$urandom, $urandom};
      drive_cycle(ev, erd, ed, lv, lrd, ldd);
      n_vec++; if (obs_ex_ready !== exp_ex_ready || obs_ld_ready !== exp_ld_ready || obs_ld_count !== 2'(exp_ld_count)) begin
        n_err++; $display("FAIL rand_ready_c%0d: ex_ready=%b ld_ready=%b count=%0d want %b %b %0d",
                          c, obs_ex_ready, obs_ld_ready, obs_ld_count, exp_ex_ready, exp_ld_ready, exp_ld_count);
      end
      n_vec++; if (wb_en !== exp_wb_en || sb_clr !== exp_sb_clr || sb_clr_rd !== exp_sb_clr_rd) begin
        n_err++; $display("FAIL rand_ctrl_c%0d: en=%b clr=%b rd=%0d want %b %b %0d",
                          c, wb_en, sb_clr, sb_clr_rd, exp_wb_en, exp_sb_clr, exp_sb_clr_rd);
      end
      n_vec++; if (wb_addr !== exp_wb_addr || wb_data !== exp_wb_data) begin
        n_err++; $display("FAIL rand_wb_c%0d: addr=%0d data=%h want %0d %h", c, wb_addr, wb_data, exp_wb_addr, exp_wb_data);
      end
    end
  endtask

`ifdef GPR_WB_BYPASS_EN
  task automatic test_bypass();
    drain();
    drive_cycle(1, 5'd9, 64'h1234, 0, '0, '0);
    n_vec++; if (obs_byp_valid !== 1'b1 || obs_byp_rd !== 5'd9 || obs_byp_data !== 64'h1234) begin
      n_err++; $display("FAIL bypass_same_cycle: v=%b rd=%0d d=%h want 1 9 1234", obs_byp_valid, obs_byp_rd, obs_byp_data);
    end
    n_vec++; if (wb_en !== 1'b1) begin n_err++; $display("FAIL bypass_wb_en: got %b want 1", wb_en); end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_ex_only();
    test_starvation();
    test_fifo_full();
    test_rd0();
    test_mid_reset();
    test_random();
`ifdef GPR_WB_BYPASS_EN
    test_bypass();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
